// File: rtl/branch_unit.sv
// Branch resolution unit: latches a branch request, waits for any pending flag
// write, evaluates the condition against flag_Z/flag_N and issues a one-cycle PC redirect.
module branch_unit #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  branch_reset,
    input  logic                  branch_req,
    input  logic [2:0]            branch_cond,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    input  logic                  flag_Z,
    input  logic                  flag_N,
    input  logic                  flags_wr,
    output logic                  branch_busy,
    output logic                  branch_done,
    output logic                  branch_taken,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  branch_illegal,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [2:0] COND_BEQ = 3'b000;
    localparam logic [2:0] COND_BNE = 3'b001;
    localparam logic [2:0] COND_BGT = 3'b010;
    localparam logic [2:0] COND_BGE = 3'b011;
    localparam logic [2:0] COND_BLT = 3'b100;
    localparam logic [2:0] COND_BLE = 3'b101;
    localparam logic [2:0] COND_JMP = 3'b110;
    localparam logic [2:0] COND_RSV = 3'b111;

    state_t                state_reg, state_next;
    logic [2:0]            cond_reg;
    logic [ADDR_WIDTH-1:0] target_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic                  taken_reg;
    logic                  done_reg;
    logic                  pc_load_reg;
    logic                  illegal_reg;
    logic [ADDR_WIDTH-1:0] pc_next_reg;
    logic [CNT_WIDTH-1:0]  taken_count_reg;
    logic                  cond_true;

    always_ff @(posedge clock or negedge branch_reset) begin
        if (!branch_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (branch_req) begin
                    state_next = flags_wr ? WAIT_FLAGS : EVAL;
                end
            end
            WAIT_FLAGS: begin
                if (!flags_wr) begin
                    state_next = EVAL;
                end
            end
            EVAL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flags are read live: by the EVAL edge any earlier write has landed.
    always_comb begin
        cond_true = 1'b0;
        case (cond_reg)
            COND_BEQ: cond_true = flag_Z;
            COND_BNE: cond_true = !flag_Z;
            COND_BGT: cond_true = !flag_Z && !flag_N;
            COND_BGE: cond_true = !flag_N;
            COND_BLT: cond_true = flag_N;
            COND_BLE: cond_true = flag_Z || flag_N;
            COND_JMP: cond_true = 1'b1;
            COND_RSV: cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge branch_reset) begin
        if (!branch_reset) begin
            cond_reg        <= '0;
            target_reg      <= '0;
            pc_reg          <= '0;
            taken_reg       <= 1'b0;
            done_reg        <= 1'b0;
            pc_load_reg     <= 1'b0;
            illegal_reg     <= 1'b0;
            pc_next_reg     <= '0;
            taken_count_reg <= '0;
        end else begin
            done_reg    <= 1'b0;
            pc_load_reg <= 1'b0;
            illegal_reg <= 1'b0;
            if (state_reg == IDLE && branch_req) begin
                cond_reg   <= branch_cond;
                target_reg <= branch_target;
                pc_reg     <= pc_current;
            end
            if (state_reg == EVAL) begin
                taken_reg   <= cond_true;
                pc_next_reg <= cond_true ? target_reg : pc_reg + ADDR_WIDTH'(1);
                done_reg    <= 1'b1;
                pc_load_reg <= cond_true;
                illegal_reg <= (cond_reg == COND_RSV);
                if (cond_true && taken_count_reg != {CNT_WIDTH{1'b1}}) begin
                    taken_count_reg <= taken_count_reg + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign branch_busy    = (state_reg != IDLE);
    assign branch_done    = done_reg;
    assign branch_taken   = taken_reg;
    assign pc_load        = pc_load_reg;
    assign pc_next        = pc_next_reg;
    assign branch_illegal = illegal_reg;
    assign taken_count    = taken_count_reg;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: condition resolution, flag-write
// stalls, reserved code, back-to-back throughput with counter saturation, reset abort.
module tb_branch_unit;

    localparam int AW = 11;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          branch_reset;
    logic          branch_req;
    logic [2:0]    branch_cond;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] pc_current;
    logic          flag_Z;
    logic          flag_N;
    logic          flags_wr;
    logic          branch_busy;
    logic          branch_done;
    logic          branch_taken;
    logic          pc_load;
    logic [AW-1:0] pc_next;
    logic          branch_illegal;
    logic [CW-1:0] taken_count;

    int checks = 0;
    int errors = 0;

    branch_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clock         (clock),
        .branch_reset  (branch_reset),
        .branch_req    (branch_req),
        .branch_cond   (branch_cond),
        .branch_target (branch_target),
        .pc_current    (pc_current),
        .flag_Z        (flag_Z),
        .flag_N        (flag_N),
        .flags_wr      (flags_wr),
        .branch_busy   (branch_busy),
        .branch_done   (branch_done),
        .branch_taken  (branch_taken),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .branch_illegal(branch_illegal),
        .taken_count   (taken_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        branch_reset = 1'b0;
        branch_req = 1'b0; branch_cond = 3'b000; branch_target = '0; pc_current = '0;
        flag_Z = 1'b0; flag_N = 1'b0; flags_wr = 1'b0;
        step(); step();
        checks++; if (branch_busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", branch_busy); errors++; end
        checks++; if (branch_done !== 1'b0) begin $display("FAIL reset_done got %b exp 0", branch_done); errors++; end
        checks++; if (pc_next !== 11'h000) begin $display("FAIL reset_pc_next got %h exp 000", pc_next); errors++; end
        checks++; if (taken_count !== 8'd0) begin $display("FAIL reset_count got %0d exp 0", taken_count); errors++; end
        checks++; if ({branch_taken, pc_load, branch_illegal} !== 3'b000) begin
            $display("FAIL reset_flags got %b exp 000", {branch_taken, pc_load, branch_illegal}); errors++; end
        branch_reset = 1'b1;
        step();
        $display("reset: outputs cleared");
    endtask

    task automatic test_beq_taken();
        flag_Z = 1'b1; flag_N = 1'b0; flags_wr = 1'b0;
        branch_cond = 3'b000; branch_target = 11'h155; pc_current = 11'h010; branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        checks++; if (branch_busy !== 1'b1 || branch_done !== 1'b0) begin
            $display("FAIL beq_accept busy/done got %b%b exp 10", branch_busy, branch_done); errors++; end
        step();
        checks++; if (branch_done !== 1'b1) begin $display("FAIL beq_done got %b exp 1", branch_done); errors++; end
        checks++; if (branch_taken !== 1'b1 || pc_load !== 1'b1) begin
            $display("FAIL beq_taken taken/pc_load got %b%b exp 11", branch_taken, pc_load); errors++; end
        checks++; if (pc_next !== 11'h155) begin $display("FAIL beq_pc_next got %h exp 155", pc_next); errors++; end
        checks++; if (taken_count !== 8'd1) begin $display("FAIL beq_count got %0d exp 1", taken_count); errors++; end
        step();
        checks++; if (branch_done !== 1'b0 || pc_load !== 1'b0 || branch_busy !== 1'b0) begin
            $display("FAIL beq_clear done/load/busy got %b%b%b exp 000", branch_done, pc_load, branch_busy); errors++; end
        checks++; if (pc_next !== 11'h155 || branch_taken !== 1'b1) begin
            $display("FAIL beq_hold pc_next %h taken %b exp 155 1", pc_next, branch_taken); errors++; end
        $display("beq: target=155 pc=010 -> taken pc_next=%h count=%0d", pc_next, taken_count);
    endtask

    task automatic test_bgt_wrap();
        flag_Z = 1'b0; flag_N = 1'b1;
        branch_cond = 3'b010; branch_target = 11'h200; pc_current = 11'h7FF; branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        step();
        checks++; if (branch_done !== 1'b1) begin $display("FAIL bgt_done got %b exp 1", branch_done); errors++; end
        checks++; if (branch_taken !== 1'b0 || pc_load !== 1'b0) begin
            $display("FAIL bgt_not_taken taken/pc_load got %b%b exp 00", branch_taken, pc_load); errors++; end
        checks++; if (pc_next !== 11'h000) begin $display("FAIL bgt_wrap pc_next got %h exp 000", pc_next); errors++; end
        checks++; if (taken_count !== 8'd1) begin $display("FAIL bgt_count got %0d exp 1", taken_count); errors++; end
        step();
        $display("bgt: pc=7FF not taken -> pc_next=%h", pc_next);
    endtask

    task automatic test_wait_flags();
        flag_Z = 1'b0; flag_N = 1'b0; flags_wr = 1'b1;
        branch_cond = 3'b100; branch_target = 11'h3C0; pc_current = 11'h050; branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        flag_N = 1'b1;
        checks++; if (branch_busy !== 1'b1 || branch_done !== 1'b0) begin
            $display("FAIL wait_1 busy/done got %b%b exp 10", branch_busy, branch_done); errors++; end
        step();
        flags_wr = 1'b0;
        checks++; if (branch_busy !== 1'b1 || branch_done !== 1'b0) begin
            $display("FAIL wait_2 busy/done got %b%b exp 10", branch_busy, branch_done); errors++; end
        step();
        checks++; if (branch_done !== 1'b0) begin $display("FAIL wait_eval done got %b exp 0", branch_done); errors++; end
        step();
        checks++; if (branch_done !== 1'b1) begin $display("FAIL wait_done got %b exp 1", branch_done); errors++; end
        checks++; if (branch_taken !== 1'b1 || pc_load !== 1'b1 || pc_next !== 11'h3C0) begin
            $display("FAIL wait_decision taken %b load %b pc_next %h exp 1 1 3C0", branch_taken, pc_load, pc_next); errors++; end
        checks++; if (taken_count !== 8'd2) begin $display("FAIL wait_count got %0d exp 2", taken_count); errors++; end
        step();
        $display("blt: two flag-write stalls, N=1 -> taken pc_next=%h", pc_next);
    endtask

    task automatic test_illegal();
        branch_cond = 3'b111; branch_target = 11'h0AA; pc_current = 11'h100; branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        step();
        checks++; if (branch_done !== 1'b1 || branch_illegal !== 1'b1) begin
            $display("FAIL illegal_pulse done/illegal got %b%b exp 11", branch_done, branch_illegal); errors++; end
        checks++; if (branch_taken !== 1'b0 || pc_load !== 1'b0) begin
            $display("FAIL illegal_not_taken taken/load got %b%b exp 00", branch_taken, pc_load); errors++; end
        checks++; if (pc_next !== 11'h101) begin $display("FAIL illegal_pc_next got %h exp 101", pc_next); errors++; end
        step();
        checks++; if (branch_illegal !== 1'b0) begin $display("FAIL illegal_clear got %b exp 0", branch_illegal); errors++; end
        $display("rsv: cond=111 -> illegal, pc_next=%h", pc_next);
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int last_cycle = -1;
        int exp_count = 2;
        int bad_gap = 0;
        int bad_cnt = 0;
        branch_cond = 3'b110; branch_target = 11'h444; pc_current = 11'h222; branch_req = 1'b1;
        for (int cyc = 0; cyc < 900 && n_done < 260; cyc++) begin
            step();
            if (branch_done === 1'b1) begin
                n_done++;
                if (exp_count < 255) exp_count++;
                if (last_cycle >= 0 && cyc - last_cycle != 3) bad_gap++;
                if (taken_count !== 8'(exp_count)) bad_cnt++;
                last_cycle = cyc;
            end
        end
        branch_req = 1'b0;
        checks++; if (n_done != 260) begin $display("FAIL b2b_done_count got %0d exp 260", n_done); errors++; end
        checks++; if (bad_gap != 0) begin $display("FAIL b2b_spacing bad gaps %0d exp 0", bad_gap); errors++; end
        checks++; if (bad_cnt != 0) begin $display("FAIL b2b_count_track mismatched pulses %0d exp 0", bad_cnt); errors++; end
        checks++; if (taken_count !== 8'd255) begin $display("FAIL b2b_saturate got %0d exp 255", taken_count); errors++; end
        step(); step();
        checks++; if (branch_busy !== 1'b0) begin $display("FAIL b2b_idle busy got %b exp 0", branch_busy); errors++; end
        $display("jmp x260 back-to-back: count=%0d", taken_count);
    endtask

    task automatic test_reset_abort();
        flag_Z = 1'b1; flag_N = 1'b0; flags_wr = 1'b0;
        branch_cond = 3'b000; branch_target = 11'h321; pc_current = 11'h011; branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        #2 branch_reset = 1'b0;
        #1;
        checks++; if ({branch_busy, branch_done, branch_taken, pc_load, branch_illegal} !== 5'b00000) begin
            $display("FAIL abort_flags got %b exp 00000", {branch_busy, branch_done, branch_taken, pc_load, branch_illegal}); errors++; end
        checks++; if (pc_next !== 11'h000 || taken_count !== 8'd0) begin
            $display("FAIL abort_regs pc_next %h count %0d exp 000 0", pc_next, taken_count); errors++; end
        step();
        checks++; if (branch_done !== 1'b0) begin $display("FAIL abort_no_done got %b exp 0", branch_done); errors++; end
        #3 branch_reset = 1'b1;
        branch_req = 1'b1;
        step();
        branch_req = 1'b0;
        step();
        checks++; if (branch_done !== 1'b1 || branch_taken !== 1'b1 || pc_next !== 11'h321) begin
            $display("FAIL abort_recover done %b taken %b pc_next %h exp 1 1 321", branch_done, branch_taken, pc_next); errors++; end
        checks++; if (taken_count !== 8'd1) begin $display("FAIL abort_recount got %0d exp 1", taken_count); errors++; end
        step();
        $display("reset abort during EVAL, then recovered branch pc_next=%h", pc_next);
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bgt_wrap();
        test_wait_flags();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer side of the status flags register: reads flag_Z/flag_N and resolves conditional and unconditional branches for the control unit.
- On request it waits out any in-flight flag write, evaluates the condition, then drives a one-cycle PC redirect with the target or the fall-through address.
- Sits between the flags register and the program counter.
- Keeps a saturating count of taken branches for debug.

Parameters:
ADDR_WIDTH, 11, width of program addresses (matches flags datapath width)
CNT_WIDTH, 8, width of the taken-branch counter

Ports:
clock  input  1  system clock, rising-edge
branch_reset  input  1  asynchronous, active-low reset
branch_req  input  1  branch request, sampled only while branch_busy=0
branch_cond  input  3  condition code, latched with request
branch_target  input  ADDR_WIDTH  taken destination, latched with request
pc_current  input  ADDR_WIDTH  address of branch instruction, latched with request
flag_Z  input  1  zero flag from flags register
flag_N  input  1  negative flag from flags register
flags_wr  input  1  flags register write strobe (flag update pending)
branch_busy  output  1  high from accept until return to IDLE
branch_done  output  1  one-cycle completion pulse
branch_taken  output  1  decision, valid while branch_done=1
pc_load  output  1  one-cycle PC load strobe, only when taken
pc_next  output  ADDR_WIDTH  resolved address, held until next decision
branch_illegal  output  1  pulses with branch_done for reserved code
taken_count  output  CNT_WIDTH  saturating count of taken branches

Behaviour:
- Reset (branch_reset=0, asynchronous): state IDLE. All outputs are 0, including pc_next and taken_count. Reset mid-operation aborts with no done pulse.
- Condition codes:
  - 000 BEQ: Z=1
  - 001 BNE: Z=0
  - 010 BGT: Z=0 and N=0
  - 011 BGE: N=0
  - 100 BLT: N=1
  - 101 BLE: Z=1 or N=1
  - 110 JMP: always taken
  - 111 reserved: not taken, branch_illegal=1
- States: IDLE, WAIT_FLAGS, EVAL, DONE.
- IDLE:
  - On edge with branch_req=1, latch cond, target and pc_current.
  - If flags_wr=1 on the same edge, go to WAIT_FLAGS; otherwise go to EVAL.
- WAIT_FLAGS: stay while flags_wr=1. On edge with flags_wr=0, go to EVAL. Guarantees flags reflect the last completed write.
- EVAL:
  - At the next edge, sample flag_Z/flag_N and register the outputs below, then go to DONE.
  - branch_taken
  - pc_next = taken ? target : pc_current+1, modulo 2^ADDR_WIDTH (all-ones wraps to 0)
  - pc_load = taken
  - branch_done = 1
  - branch_illegal = (cond==111)
- EVAL, flags_wr=1 during the cycle: no re-wait. The flags sampled at the EVAL edge are used.
- DONE: branch_done/pc_load/branch_illegal high for exactly this cycle, then go to IDLE. They clear on the next edge.
- Latency: with no flag write pending, the request edge is E0, the decision is registered at E1, and done is visible E1–E2. Request-to-done is 1 cycle. Each WAIT_FLAGS cycle adds 1.
- branch_busy: 1 in WAIT_FLAGS, EVAL and DONE. branch_req is ignored while busy; there is no queueing.
- A new request is accepted in the first IDLE cycle after DONE. Back-to-back throughput is one branch per 3 cycles.
- pc_next and branch_taken hold their last value between decisions.
- taken_count: increments by 1 at the EVAL→DONE edge when taken. It saturates at 2^CNT_WIDTH-1 and never wraps.

Test Plan:
1. Reset, then Z=1,N=0, flags_wr=0, req cond=000, target=0x155, pc=0x010. Required: done one cycle after accept, taken=1, pc_load=1, pc_next=0x155, taken_count=1.
2. Z=0,N=1, cond=010, target=0x200, pc=0x7FF. Required: taken=0, pc_load=0, pc_next=0x000 (wrap), done=1, count unchanged.
3. Req cond=100 with flags_wr=1 held 2 cycles; flags go N=0→N=1 on the first write. Required: busy, two WAIT_FLAGS cycles, decision uses N=1, taken=1, done 3 cycles after accept.
4. cond=111, target=0x0AA, pc=0x100. Required: branch_illegal=1 with done, taken=0, pc_next=0x101, no pc_load.
5. Assert branch_req continuously with cond=110. Required: accepts every 3 cycles, second req ignored while busy. Run 260 taken jumps: taken_count stops at 255.
6. Drop branch_reset during EVAL. Required: immediate return of all outputs to 0, no done pulse, and a request accepted normally after reset release.
